// File: rtl/seg_display_scanner.sv
// Purpose: time-multiplexes a double-buffered NUM_DIGITS nibble value onto one segment decoder and active-low anodes.
// Latency: an/bcd/blank/dp are registered one cycle behind the scan counters; a load shows at the next frame boundary.
// Backpressure: none; load is always accepted, and the newest load before a boundary is the one committed.
module seg_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int DEAD       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [3:0]              bcd,
    output logic                    blank,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] DEAD_C = PW'(DEAD);

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
    logic                    sh_lz_q, sh_lz_d, disp_lz_q, disp_lz_d;
    logic                    pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    blank_q, blank_d;
    logic                    dp_q, dp_d;

    logic                    slot_end, frame_end, in_dead, upper_zero;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;

    // Dead phase covers the first DEAD cycles of every slot; absent entirely when DEAD is 0.
    if (DEAD == 0) begin : g_no_dead
        assign in_dead = 1'b0;
    end else begin : g_dead
        assign in_dead = (pcnt_q < DEAD_C);
    end

    assign slot_end   = (pcnt_q == P_LAST);
    assign frame_end  = slot_end && (idx_q == I_LAST);
    assign cur_nib    = disp_val_q[{idx_q, 2'b00} +: 4];
    assign frame_done = frame_end;

    assign an    = an_q;
    assign bcd   = bcd_q;
    assign blank = blank_q;
    assign dp    = dp_q;

    // Leading-zero mask: a digit blanks when it and every digit above it are zero (digit 0 never blanks).
    always_comb begin
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero  = upper_zero & (disp_val_q[4*i +: 4] == 4'h0);
            lz_blank[i] = disp_lz_q & upper_zero & (i != 0);
        end
    end

    // Scan counters, shadow/display double buffer and next output values.
    always_comb begin
        pcnt_d     = slot_end ? '0 : pcnt_q + 1'b1;
        idx_d      = idx_q;
        sh_val_d   = sh_val_q;
        sh_dp_d    = sh_dp_q;
        sh_lz_d    = sh_lz_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        disp_lz_d  = disp_lz_q;
        pend_d     = pend_q;

        if (slot_end) begin
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
        end

        // Commit uses the pre-edge shadow, so a load in the boundary cycle waits a full frame.
        if (frame_end && pend_q) begin
            disp_val_d = sh_val_q;
            disp_dp_d  = sh_dp_q;
            disp_lz_d  = sh_lz_q;
            pend_d     = 1'b0;
        end

        if (load) begin
            sh_val_d = value;
            sh_dp_d  = dp_in;
            sh_lz_d  = lz_en;
            pend_d   = 1'b1;
        end

        an_d  = '1;
        bcd_d = cur_nib;
        if (in_dead) begin
            blank_d = 1'b1;
            dp_d    = 1'b0;
        end else begin
            an_d[idx_q] = 1'b0;
            blank_d     = lz_blank[idx_q];
            dp_d        = disp_dp_q[idx_q];
        end
    end

    // State and output registers; reset leaves all anodes off and segments blanked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q     <= '0;
            idx_q      <= '0;
            sh_val_q   <= '0;
            sh_dp_q    <= '0;
            sh_lz_q    <= 1'b0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            disp_lz_q  <= 1'b0;
            pend_q     <= 1'b0;
            an_q       <= '1;
            bcd_q      <= 4'h0;
            blank_q    <= 1'b1;
            dp_q       <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            idx_q      <= idx_d;
            sh_val_q   <= sh_val_d;
            sh_dp_q    <= sh_dp_d;
            sh_lz_q    <= sh_lz_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            disp_lz_q  <= disp_lz_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            dp_q       <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Purpose: self-checking bench for seg_display_scanner with a frame-position reference model.
// Latency: model predicts outputs one cycle behind the scan position, frame_done in the same cycle.
// Backpressure: not applicable; loads are driven as single-cycle strobes.
module tb_seg_display_scanner;

    localparam int N  = 4;
    localparam int PS = 8;
    localparam int DD = 2;
    localparam int FR = N * PS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = 4'h0;
    logic        lz_en = 1'b0;
    logic [3:0]  bcd;
    logic        blank;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int passed = 0;
    int total  = 0;

    seg_display_scanner #(.NUM_DIGITS(N), .PRESCALE(PS), .DEAD(DD)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .lz_en(lz_en), .bcd(bcd), .blank(blank), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: k counts clock edges since reset release, so the scan position is plain arithmetic on k.
    int          k;
    int          pc, ix;
    logic [15:0] m_sh, m_disp;
    logic [3:0]  m_shdp, m_dispdp;
    logic        m_shlz, m_displz, m_pend;
    logic [3:0]  e_an, e_bcd;
    logic        e_blank, e_dp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; m_sh = 0; m_disp = 0; m_shdp = 0; m_dispdp = 0;
            m_shlz = 0; m_displz = 0; m_pend = 0;
            e_an = 4'hF; e_bcd = 4'h0; e_blank = 1'b1; e_dp = 1'b0;
        end else begin
            pc    = k % PS;
            ix    = (k / PS) % N;
            e_bcd = 4'((m_disp >> (4 * ix)) & 16'hF);
            if (pc < DD) begin
                e_an = 4'hF; e_blank = 1'b1; e_dp = 1'b0;
            end else begin
                e_an    = ~(4'b1 << ix);
                e_dp    = m_dispdp[ix];
                e_blank = m_displz && (ix != 0) && ((m_disp >> (4 * ix)) == 16'h0);
            end
            if ((k % FR) == FR - 1 && m_pend) begin
                m_disp = m_sh; m_dispdp = m_shdp; m_displz = m_shlz; m_pend = 1'b0;
            end
            if (load) begin
                m_sh = value; m_shdp = dp_in; m_shlz = lz_en; m_pend = 1'b1;
            end
            k = k + 1;
        end
    end

    logic [10:0] act_vec, exp_vec;
    assign act_vec = {an, bcd, blank, dp, frame_done};
    assign exp_vec = {e_an, e_bcd, e_blank, e_dp, ((k % FR) == FR - 1)};

    logic [3:0]  o_an  [FR];
    logic [3:0]  o_bcd [FR];
    logic        o_blank [FR];
    logic        o_dp  [FR];
    logic [10:0] o_vec [FR];
    logic [10:0] x_vec [FR];
    logic [3:0]  t12af [4] = '{4'hF, 4'hA, 4'h2, 4'h1};
    logic [3:0]  t50bcd [4] = '{4'h0, 4'h5, 4'h0, 4'h0};
    logic        t50blk [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    function automatic int an_digit(input logic [3:0] a);
        an_digit = -1;
        for (int i = 0; i < 4; i++) if (a == ~(4'b1 << i)) an_digit = i;
    endfunction

    task automatic wait_pos(input int p);
        for (int i = 0; i < 2 * FR && (k % FR) != p; i++) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
        value = v; dp_in = d; lz_en = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Records one frame of DUT outputs alongside the model's prediction.
    task automatic capture_frame();
        for (int c = 0; c < FR; c++) begin
            @(negedge clk);
            o_an[c] = an; o_bcd[c] = bcd; o_blank[c] = blank; o_dp[c] = dp;
            o_vec[c] = act_vec; x_vec[c] = exp_vec;
        end
    endtask

    task automatic test_reset();
        int pulses;
        repeat (2) @(negedge clk);
        total++; if (act_vec !== {4'hF, 4'h0, 1'b1, 1'b0, 1'b0}) $display("FAIL reset_vals: got %h expected %h", act_vec, {4'hF, 4'h0, 1'b1, 1'b0, 1'b0}); else passed++;
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if (c < 3 && (an !== 4'hF || blank !== 1'b1)) $display("FAIL early_dead c=%0d: got an=%b blank=%b expected an=1111 blank=1", c, an, blank);
            else if (c == 3 && {an, bcd, blank, dp} !== {4'hE, 4'h0, 1'b0, 1'b0}) $display("FAIL first_drive: got an=%b bcd=%h blank=%b dp=%b expected an=1110 bcd=0 blank=0 dp=0", an, bcd, blank, dp);
            else passed++;
        end
        pulses = 0;
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            if (frame_done === 1'b1) pulses++;
            total++; if (act_vec !== exp_vec) $display("FAIL idle_scan k=%0d: got %h expected %h", k, act_vec, exp_vec); else passed++;
        end
        total++; if (pulses !== 2) $display("FAIL frame_done_count: got %0d expected 2", pulses); else passed++;
    endtask

    task automatic test_load_12af();
        int cnt [4];
        int dead, d;
        wait_pos(10);
        do_load(16'h12AF, 4'b0100, 1'b0);
        for (int i = 0; i < 2 * FR && (k % FR) != 0; i++) begin
            @(negedge clk);
            total++; if (bcd !== 4'h0 || act_vec !== exp_vec) $display("FAIL pre_commit k=%0d: got %h expected %h", k, act_vec, exp_vec); else passed++;
        end
        capture_frame();
        dead = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < FR; c++) begin
            d = an_digit(o_an[c]);
            total++; if (o_vec[c] !== x_vec[c]) $display("FAIL frame12af_model c=%0d: got %h expected %h", c, o_vec[c], x_vec[c]); else passed++;
            total++; if ((d >= 0) !== ((c % PS) >= DD)) $display("FAIL slot_shape c=%0d: got an=%b expected drive=%0d", c, o_an[c], (c % PS) >= DD); else passed++;
            if (d < 0) dead++;
            else begin
                cnt[d]++;
                total++;
                if (o_bcd[c] !== t12af[d] || o_dp[c] !== (d == 2) || o_blank[c] !== 1'b0)
                    $display("FAIL digit12af d=%0d: got bcd=%h dp=%b blank=%b expected bcd=%h dp=%0d blank=0", d, o_bcd[c], o_dp[c], o_blank[c], t12af[d], d == 2);
                else passed++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (cnt[i] !== PS - DD) $display("FAIL drive_len d=%0d: got %0d expected %0d", i, cnt[i], PS - DD); else passed++;
        end
        total++; if (dead !== N * DD) $display("FAIL dead_len: got %0d expected %0d", dead, N * DD); else passed++;
    endtask

    task automatic test_leading_zeros();
        int d;
        do_load(16'h0050, 4'h0, 1'b1);
        wait_pos(0);
        capture_frame();
        for (int c = 0; c < FR; c++) begin
            d = an_digit(o_an[c]);
            total++; if (o_vec[c] !== x_vec[c]) $display("FAIL lz50_model c=%0d: got %h expected %h", c, o_vec[c], x_vec[c]); else passed++;
            if (d >= 0) begin
                total++;
                if (o_bcd[c] !== t50bcd[d] || o_blank[c] !== t50blk[d]) $display("FAIL lz50 d=%0d: got bcd=%h blank=%b expected bcd=%h blank=%b", d, o_bcd[c], o_blank[c], t50bcd[d], t50blk[d]);
                else passed++;
            end
        end
        do_load(16'h0000, 4'h0, 1'b1);
        wait_pos(0);
        capture_frame();
        for (int c = 0; c < FR; c++) begin
            d = an_digit(o_an[c]);
            if (d >= 0) begin
                total++;
                if (o_bcd[c] !== 4'h0 || o_blank[c] !== (d != 0)) $display("FAIL lz0000 d=%0d: got bcd=%h blank=%b expected bcd=0 blank=%0d", d, o_bcd[c], o_blank[c], d != 0);
                else passed++;
            end
        end
    endtask

    task automatic test_boundary_load();
        wait_pos(5);
        do_load(16'h2222, 4'h0, 1'b0);
        wait_pos(FR - 1);
        total++; if (frame_done !== 1'b1) $display("FAIL boundary_fd: got %b expected 1", frame_done); else passed++;
        do_load(16'h1111, 4'h0, 1'b0);
        capture_frame();
        for (int c = 0; c < FR; c++) begin
            total++; if (o_vec[c] !== x_vec[c] || (an_digit(o_an[c]) >= 0 && o_bcd[c] !== 4'h2)) $display("FAIL boundary_2222 c=%0d: got %h expected %h bcd=2", c, o_vec[c], x_vec[c]); else passed++;
        end
        capture_frame();
        for (int c = 0; c < FR; c++) begin
            total++; if (o_vec[c] !== x_vec[c] || (an_digit(o_an[c]) >= 0 && o_bcd[c] !== 4'h1)) $display("FAIL boundary_1111 c=%0d: got %h expected %h bcd=1", c, o_vec[c], x_vec[c]); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        wait_pos(3);
        do_load(16'hAAAA, 4'h0, 1'b0);
        do_load(16'h5555, 4'h0, 1'b0);
        wait_pos(0);
        repeat (2) begin
            capture_frame();
            for (int c = 0; c < FR; c++) begin
                total++; if (o_vec[c] !== x_vec[c] || (an_digit(o_an[c]) >= 0 && o_bcd[c] !== 4'h5)) $display("FAIL last_wins c=%0d: got %h expected %h bcd=5", c, o_vec[c], x_vec[c]); else passed++;
            end
        end
    endtask

    task automatic test_random();
        int gap;
        for (int it = 0; it < 16; it++) begin
            gap = $urandom_range(0, 40);
            for (int c = 0; c < gap; c++) begin
                @(negedge clk);
                total++; if (act_vec !== exp_vec) $display("FAIL random k=%0d: got %h expected %h", k, act_vec, exp_vec); else passed++;
            end
            do_load(16'($urandom), 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) do_load(16'($urandom) & 16'h00FF, 4'($urandom), 1'b1);
        end
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            total++; if (act_vec !== exp_vec) $display("FAIL random_tail k=%0d: got %h expected %h", k, act_vec, exp_vec); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        do_load(16'h0000, 4'h0, 1'b0);
        wait_pos(0);
        wait_pos(3);
        do_load(16'h9999, 4'hF, 1'b0);
        wait_pos(21);
        total++; if (an !== 4'b1011) $display("FAIL pre_reset_an: got %b expected 1011", an); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (act_vec !== {4'hF, 4'h0, 1'b1, 1'b0, 1'b0}) $display("FAIL async_reset: got %h expected %h", act_vec, {4'hF, 4'h0, 1'b1, 1'b0, 1'b0}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            capture_frame();
            for (int c = 0; c < FR; c++) begin
                total++;
                if (o_vec[c] !== x_vec[c] || o_bcd[c] !== 4'h0 || o_dp[c] !== 1'b0) $display("FAIL post_reset c=%0d: got %h expected %h bcd=0 dp=0", c, o_vec[c], x_vec[c]);
                else passed++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_12af();
        test_leading_zeros();
        test_boundary_load();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Time-multiplexes a NUM_DIGITS-digit hex/BCD value onto one shared seven-segment decoder and a set of active-low digit enables.
- Sits directly upstream of the nibble-to-segment decoder: drives its 4-bit nibble input, plus blank and decimal-point controls, and the board anode lines.
- Double-buffers the displayed value so that updates take effect only at frame boundaries, which prevents tearing.
- Inserts a dead time at the start of each digit slot to suppress ghosting.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, range 2..8.
- PRESCALE, 50000: clock cycles per digit slot. Must be at least 2.
- DEAD, 4: cycles at the start of each slot with all anodes off. Range 0..PRESCALE-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*NUM_DIGITS  packed nibbles; nibble i = value[4i+3:4i], digit 0 is least significant.
- load  in  1  one-cycle strobe that captures value, dp_in and lz_en into the shadow register.
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- lz_en  in  1  leading-zero blanking enable.
- bcd  out  4  nibble for the downstream segment decoder.
- blank  out  1  1 = downstream segments must be forced off.
- dp  out  1  decimal point for the currently driven digit.
- an  out  NUM_DIGITS  digit enables, active-low; at most one bit is low at any time.
- frame_done  out  1  one-cycle pulse in the last cycle of each frame.

Behaviour:
- Reset (asynchronous, rst_n=0) clears the following:
  - prescaler=0, digit index=0;
  - shadow value, display value, shadow dp, display dp = 0; lz flags=0; pending=0;
  - outputs: an=all 1s, bcd=0, blank=1, dp=0, frame_done=0.
- Prescaler: counts 0..PRESCALE-1 and wraps. On wrap (pcnt==PRESCALE-1), idx advances 0..NUM_DIGITS-1 and wraps to 0.
- Frame boundary: the cycle with pcnt==PRESCALE-1 and idx==NUM_DIGITS-1. frame_done is combinationally high exactly in this cycle.
- Load path:
  - load=1 writes value, dp_in and lz_en to the shadow and sets pending=1.
  - A second load before the boundary overwrites the shadow; the last one wins.
- Commit at the frame boundary edge:
  - If pending=1 (pre-edge state), the shadow copies to the display registers and pending clears.
  - A load in the boundary cycle itself writes the shadow and leaves pending=1, so it commits at the next boundary.
  - The commit clear does not override a simultaneous load.
- Output registers: an, bcd, blank and dp are registered from the pre-edge pcnt/idx/display state, giving one cycle of latency relative to the counters.
  - Dead phase (pcnt<DEAD, sampled pre-edge): next an=all 1s, blank=1, bcd=nibble[idx], dp=0.
  - Drive phase (pcnt>=DEAD): next an = all 1s with bit idx low; bcd=display nibble[idx]; dp=display_dp[idx]; blank=lz_blank(idx).
- lz_blank(i): 1 iff display lz flag=1, i!=0, and display nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked, so a zero value shows "0".
- With DEAD=0, there is no dead phase and an is always one-hot low after the first cycle out of reset.
- Reset asserted mid-frame: all outputs immediately take their reset values. Pending loads are discarded. After release, scanning restarts at digit 0, pcnt=0.
- No combinational path from any input to any output.

Test Plan (PRESCALE=8, DEAD=2, NUM_DIGITS=4, frame = 32 cycles):
- Reset then idle: an=1111 and blank=1 during reset. After release, the first drive has an=1110, bcd=0, blank=0 on cycle 3. frame_done pulses every 32 cycles.
- Load value=16'h12AF, dp_in=4'b0100, lz_en=0 mid-frame:
  - display is unchanged until the boundary;
  - next frame shows bcd F,A,2,1 on an=1110,1101,1011,0111;
  - dp=1 only while an=1011;
  - each drive window lasts 6 cycles, preceded by 2 cycles of an=1111.
- Leading zeros: load 16'h0050 with lz_en=1:
  - digits 3 and 2 have blank=1;
  - digit 1 shows bcd=5, blank=0;
  - digit 0 shows bcd=0, blank=0.
  - Load 16'h0000: only digit 0 is unblanked.
- Load in the boundary cycle with 16'h1111, after an earlier load of 16'h2222 in the same frame: the next frame shows 2222; pending stays 1; the frame after that shows 1111.
- Two loads, 16'hAAAA then 16'h5555, in one frame: only 5555 is ever displayed.
- Reset pulse asserted at idx=2: an goes to 1111 asynchronously. After release, scanning resumes at digit 0 with display=0 and the prior pending load is lost.
